// File: rtl/fsm_mon_pkg.sv
// Shared types for the FSM run-time monitor: error codes, monitor phase and the error record.
package fsm_mon_pkg;

    // Widest observed-state bus the error record can carry.
    localparam int MAX_SW = 8;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        ERR_RST_MISMATCH = 2'd1,
        ERR_ILLEGAL      = 2'd2,
        ERR_STUCK        = 2'd3
    } err_code_e;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        RUN        = 1'b1
    } phase_e;

    typedef struct packed {
        err_code_e         code;
        logic [MAX_SW-1:0] prev;
        logic [MAX_SW-1:0] cur;
    } err_rec_t;

endpackage

// File: rtl/fsm_mon_err_slot.sv
// Single-entry error record with valid/ready handoff and a sticky overflow flag.
module fsm_mon_err_slot
    import fsm_mon_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     raise,
    input  err_rec_t new_rec,
    input  logic     ready,
    output logic     valid,
    output err_rec_t rec,
    output logic     overflow
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;
            rec      <= '0;
            overflow <= 1'b0;
        end else begin
            // A record being accepted this edge frees the slot for a same-cycle error.
            if (raise && (!valid || ready)) begin
                valid <= 1'b1;
                rec   <= new_rec;
            end else if (valid && ready) begin
                valid    <= 1'b0;
                rec.code <= ERR_NONE;
            end
            if (raise && valid && !ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fsm_runtime_monitor.sv
// Run-time checker beside a small FSM: reset value, legal transitions, stuck states, cover visits.
// Errors leave through a single-entry valid/ready record; status bits are sticky until reset.
module fsm_runtime_monitor
    import fsm_mon_pkg::*;
#(
    parameter int                          SW          = 2,
    parameter logic [SW-1:0]               RESET_STATE = '0,
    parameter logic [(2**SW)*(2**SW)-1:0]  LEGAL_MASK  = '1,
    parameter logic [SW-1:0]               COVER_STATE = SW'(3),
    parameter int                          STUCK_LIMIT = 16,
    parameter int                          CW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mon_en,
    input  logic [SW-1:0] mon_state,
    output logic          err_valid,
    input  logic          err_ready,
    output logic [1:0]    err_code,
    output logic [SW-1:0] err_prev,
    output logic [SW-1:0] err_cur,
    output logic          err_overflow,
    output logic          cover_hit,
    output logic [CW-1:0] cover_count
);

    localparam int              DW        = $clog2(STUCK_LIMIT + 1);
    localparam logic [DW-1:0]   DWELL_MAX = DW'(STUCK_LIMIT);

    phase_e        phase_q, phase_d;
    logic [SW-1:0] prev_q, prev_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          stuck_q, stuck_d;
    err_code_e     raise_code;
    err_rec_t      raise_rec;
    err_rec_t      slot_rec;

    always_comb begin
        // NOTE: every output of this block gets a default before any branch, so no latch is inferred.
        phase_d    = phase_q;
        prev_d     = prev_q;
        dwell_d    = dwell_q;
        stuck_d    = stuck_q;
        raise_code = ERR_NONE;
        if (mon_en) begin
            prev_d = mon_state;
            if (phase_q == WAIT_FIRST) begin
                phase_d = RUN;
                dwell_d = DW'(1);
                stuck_d = 1'b0;
                if (mon_state != RESET_STATE) raise_code = ERR_RST_MISMATCH;
            end else begin
                if (mon_state == prev_q) begin
                    if (dwell_q != DWELL_MAX) dwell_d = dwell_q + 1'b1;
                    if (dwell_d == DWELL_MAX && !stuck_q) begin
                        stuck_d    = 1'b1;
                        raise_code = ERR_STUCK;
                    end
                end else begin
                    dwell_d = DW'(1);
                    stuck_d = 1'b0;
                end
                // {prev, cur} is prev*NS + cur; written last so it outranks STUCK.
                if (!LEGAL_MASK[{prev_q, mon_state}]) raise_code = ERR_ILLEGAL;
            end
        end
        raise_rec.code = raise_code;
        raise_rec.prev = MAX_SW'((phase_q == WAIT_FIRST) ? mon_state : prev_q);
        raise_rec.cur  = MAX_SW'(mon_state);
    end

    // NOTE: all monitor state is plain flops (no memories), so every bit is cleared by the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= WAIT_FIRST;
            prev_q      <= '0;
            dwell_q     <= '0;
            stuck_q     <= 1'b0;
            cover_hit   <= 1'b0;
            cover_count <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop reading pre-edge values.
            phase_q <= phase_d;
            prev_q  <= prev_d;
            dwell_q <= dwell_d;
            stuck_q <= stuck_d;
            if (mon_en && mon_state == COVER_STATE) begin
                cover_hit <= 1'b1;
                if (cover_count != '1) cover_count <= cover_count + 1'b1;
            end
        end
    end

    fsm_mon_err_slot u_err_slot (
        .clk      (clk),
        .rst      (rst),
        .raise    (raise_code != ERR_NONE),
        .new_rec  (raise_rec),
        .ready    (err_ready),
        .valid    (err_valid),
        .rec      (slot_rec),
        .overflow (err_overflow)
    );

    assign err_code = slot_rec.code;
    assign err_prev = slot_rec.prev[SW-1:0];
    assign err_cur  = slot_rec.cur[SW-1:0];

    // Upper record bits are zero padding beyond SW; fold them into a sink.
    logic unused_rec_pad;
    assign unused_rec_pad = ^{slot_rec.prev, slot_rec.cur};

endmodule

// File: tb/tb_fsm_runtime_monitor.sv
// Self-checking bench: directed scenarios plus randomized traffic against a rule-level model.
module tb_fsm_runtime_monitor;

    typedef struct packed {
        bit         first;
        logic [1:0] last;
        int         run_len;
        int         cnt;
        bit         hit;
        bit         valid;
        logic [1:0] code;
        logic [1:0] prev;
        logic [1:0] cur;
        bit         ovf;
    } model_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mon_en = 1'b0;
    logic        err_ready = 1'b0;
    logic [1:0]  mon_state = 2'd0;

    logic        e0_valid, e0_ovf, c0_hit;
    logic [1:0]  e0_code, e0_prev, e0_cur;
    logic [15:0] c0_cnt;
    logic        e1_valid, e1_ovf, c1_hit;
    logic [1:0]  e1_code, e1_prev, e1_cur;
    logic [3:0]  c1_cnt;

    int     tests = 0;
    int     fails = 0;
    model_t m0, m1;

    always #5 clk = ~clk;

    // Ring mask: n->n and n->n+1 (mod 4) legal.
    fsm_runtime_monitor #(.SW(2), .LEGAL_MASK(16'h9C63)) dut0 (
        .clk(clk), .rst(rst), .mon_en(mon_en), .mon_state(mon_state),
        .err_valid(e0_valid), .err_ready(err_ready), .err_code(e0_code),
        .err_prev(e0_prev), .err_cur(e0_cur), .err_overflow(e0_ovf),
        .cover_hit(c0_hit), .cover_count(c0_cnt)
    );

    fsm_runtime_monitor #(.SW(2), .CW(4), .STUCK_LIMIT(32)) dut1 (
        .clk(clk), .rst(rst), .mon_en(mon_en), .mon_state(mon_state),
        .err_valid(e1_valid), .err_ready(err_ready), .err_code(e1_code),
        .err_prev(e1_prev), .err_cur(e1_cur), .err_overflow(e1_ovf),
        .cover_hit(c1_hit), .cover_count(c1_cnt)
    );

    function automatic model_t model_reset();
        model_t m;
        m = '0;
        m.first = 1'b1;
        return m;
    endfunction

    // One clock edge of the monitor's rules, reset value 0, cover state 3.
    function automatic model_t model_step(model_t m, bit en, logic [1:0] st, bit rdy,
                                          int limit, int cmax, bit ring_mask);
        model_t     n;
        int         code;
        logic [1:0] p;
        logic [1:0] d;
        n = m;
        code = 0;
        p = st;
        if (en) begin
            if (m.first) begin
                if (st != 2'd0) code = 1;
                n.first = 1'b0;
                n.run_len = 1;
            end else begin
                p = m.last;
                n.run_len = (st == m.last) ? m.run_len + 1 : 1;
                if (st == m.last && n.run_len == limit) code = 3;
                d = st - m.last;
                if (ring_mask && d > 2'd1) code = 2;
            end
            n.last = st;
            if (st == 2'd3) begin
                n.hit = 1'b1;
                if (m.cnt < cmax) n.cnt = m.cnt + 1;
            end
        end
        if (code != 0) begin
            if (!m.valid || rdy) begin
                n.valid = 1'b1;
                n.code  = 2'(code);
                n.prev  = p;
                n.cur   = st;
            end else begin
                n.ovf = 1'b1;
            end
        end else if (m.valid && rdy) begin
            n.valid = 1'b0;
            n.code  = 2'd0;
        end
        return n;
    endfunction

    task automatic tick(input bit en, input logic [1:0] st, input bit rdy);
        mon_en = en;
        mon_state = st;
        err_ready = rdy;
        @(posedge clk);
        m0 = model_step(m0, en, st, rdy, 16, 65535, 1'b1);
        m1 = model_step(m1, en, st, rdy, 32, 15, 1'b0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mon_en = 1'b0;
        err_ready = 1'b0;
        m0 = model_reset();
        m1 = model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({e0_valid, e0_code, e0_prev, e0_cur, e0_ovf, c0_hit, c0_cnt} !== 24'd0) begin
            fails++;
            $display("FAIL reset_dut0: got %h want 0",
                     {e0_valid, e0_code, e0_prev, e0_cur, e0_ovf, c0_hit, c0_cnt});
        end
        tests++;
        if ({e1_valid, e1_code, e1_prev, e1_cur, e1_ovf, c1_hit, c1_cnt} !== 12'd0) begin
            fails++;
            $display("FAIL reset_dut1: got %h want 0",
                     {e1_valid, e1_code, e1_prev, e1_cur, e1_ovf, c1_hit, c1_cnt});
        end
    endtask

    task automatic test_legal_walk();
        logic [1:0] seq [5];
        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, seq[i], 1'b1);
            tests++;
            if (e0_valid !== 1'b0) begin
                fails++;
                $display("FAIL walk_no_err step %0d: got valid=%b want 0", i, e0_valid);
            end
        end
        tests++;
        if (c0_hit !== 1'b1 || c0_cnt !== 16'd1) begin
            fails++;
            $display("FAIL walk_cover: got hit=%b count=%0d want hit=1 count=1", c0_hit, c0_cnt);
        end
    endtask

    task automatic test_rst_mismatch();
        do_reset();
        tick(1'b1, 2'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({e0_valid, e0_code, e0_prev, e0_cur} !== {1'b1, 2'd1, 2'd2, 2'd2}) begin
                fails++;
                $display("FAIL rst_mismatch_hold %0d: got v=%b c=%0d p=%0d q=%0d want v=1 c=1 p=2 q=2",
                         i, e0_valid, e0_code, e0_prev, e0_cur);
            end
            if (i < 3) tick(1'b1, 2'd2, 1'b0);
        end
        tick(1'b0, 2'd2, 1'b1);
        tests++;
        if (e0_valid !== 1'b0 || e0_code !== 2'd0) begin
            fails++;
            $display("FAIL rst_mismatch_accept: got v=%b c=%0d want v=0 c=0", e0_valid, e0_code);
        end
    endtask

    task automatic test_illegal_overflow();
        do_reset();
        tick(1'b1, 2'd0, 1'b1);
        tick(1'b1, 2'd2, 1'b0);
        tests++;
        if ({e0_valid, e0_code, e0_prev, e0_cur} !== {1'b1, 2'd2, 2'd0, 2'd2}) begin
            fails++;
            $display("FAIL illegal_0_2: got v=%b c=%0d p=%0d q=%0d want v=1 c=2 p=0 q=2",
                     e0_valid, e0_code, e0_prev, e0_cur);
        end
        tick(1'b0, 2'd2, 1'b1);
        tick(1'b1, 2'd2, 1'b0);
        tick(1'b1, 2'd0, 1'b0);
        tests++;
        if ({e0_valid, e0_code, e0_prev, e0_cur, e0_ovf} !== {1'b1, 2'd2, 2'd2, 2'd0, 1'b0}) begin
            fails++;
            $display("FAIL illegal_2_0: got v=%b c=%0d p=%0d q=%0d ovf=%b want v=1 c=2 p=2 q=0 ovf=0",
                     e0_valid, e0_code, e0_prev, e0_cur, e0_ovf);
        end
        tick(1'b1, 2'd2, 1'b0);
        tests++;
        if ({e0_valid, e0_prev, e0_cur, e0_ovf} !== {1'b1, 2'd2, 2'd0, 1'b1}) begin
            fails++;
            $display("FAIL overflow: got v=%b p=%0d q=%0d ovf=%b want v=1 p=2 q=0 ovf=1",
                     e0_valid, e0_prev, e0_cur, e0_ovf);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick(1'b1, 2'd0, 1'b1);
        tick(1'b1, 2'd2, 1'b1);
        tick(1'b1, 2'd0, 1'b1);
        tests++;
        if ({e0_valid, e0_code, e0_prev, e0_cur, e0_ovf} !== {1'b1, 2'd2, 2'd2, 2'd0, 1'b0}) begin
            fails++;
            $display("FAIL back_to_back: got v=%b c=%0d p=%0d q=%0d ovf=%b want v=1 c=2 p=2 q=0 ovf=0",
                     e0_valid, e0_code, e0_prev, e0_cur, e0_ovf);
        end
    endtask

    task automatic test_stuck();
        int raised;
        do_reset();
        tick(1'b1, 2'd0, 1'b1);
        raised = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(1'b1, 2'd1, 1'b1);
            if (e0_valid === 1'b1) raised++;
            tests++;
            if (e0_valid !== (k == 16) ||
                (k == 16 && {e0_code, e0_prev, e0_cur} !== {2'd3, 2'd1, 2'd1})) begin
                fails++;
                $display("FAIL stuck_hold sample %0d: got v=%b c=%0d p=%0d q=%0d want v=%0d c=3 p=1 q=1",
                         k, e0_valid, e0_code, e0_prev, e0_cur, (k == 16));
            end
        end
        tests++;
        if (raised != 1) begin
            fails++;
            $display("FAIL stuck_once: got %0d records want 1", raised);
        end
        for (int k = 1; k <= 16; k++) tick(1'b1, 2'd2, 1'b1);
        tests++;
        if ({e0_valid, e0_code, e0_prev, e0_cur} !== {1'b1, 2'd3, 2'd2, 2'd2}) begin
            fails++;
            $display("FAIL stuck_rearm: got v=%b c=%0d p=%0d q=%0d want v=1 c=3 p=2 q=2",
                     e0_valid, e0_code, e0_prev, e0_cur);
        end
    endtask

    task automatic test_cover_saturate();
        do_reset();
        tick(1'b1, 2'd0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            tick(1'b1, 2'd3, 1'b1);
            tests++;
            if (c1_cnt !== 4'((k < 15) ? k : 15) || c1_hit !== 1'b1) begin
                fails++;
                $display("FAIL cover_sat sample %0d: got hit=%b count=%0d want hit=1 count=%0d",
                         k, c1_hit, c1_cnt, (k < 15) ? k : 15);
            end
        end
        tests++;
        if (e1_valid !== 1'b0 || c0_cnt !== 16'd20) begin
            fails++;
            $display("FAIL cover_wide: got dut1 valid=%b dut0 count=%0d want valid=0 count=20",
                     e1_valid, c0_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(1'b1, 2'd1, 1'b0);
        tests++;
        if (e0_valid !== 1'b1 || e1_valid !== 1'b1) begin
            fails++;
            $display("FAIL async_pre: got valid=%b/%b want 1/1", e0_valid, e1_valid);
        end
        #2 rst = 1'b1;
        m0 = model_reset();
        m1 = model_reset();
        #1;
        tests++;
        if ({e0_valid, e0_code, e0_prev, e0_cur, e0_ovf, c0_hit, c0_cnt,
             e1_valid, e1_code, e1_prev, e1_cur, e1_ovf, c1_hit, c1_cnt} !== 36'd0) begin
            fails++;
            $display("FAIL async_clear: got %h want 0",
                     {e0_valid, e0_code, e0_prev, e0_cur, e0_ovf, c0_hit, c0_cnt,
                      e1_valid, e1_code, e1_prev, e1_cur, e1_ovf, c1_hit, c1_cnt});
        end
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, 2'd0, 1'b1);
        tests++;
        if (e0_valid !== 1'b0 || e1_valid !== 1'b0) begin
            fails++;
            $display("FAIL async_first_ok: got valid=%b/%b want 0/0", e0_valid, e1_valid);
        end
    endtask

    task automatic test_random();
        logic [1:0] st;
        bit         en;
        bit         rdy;
        do_reset();
        st = 2'd0;
        for (int i = 0; i < 600; i++) begin
            en  = ($urandom_range(0, 9) != 0);
            st  = ($urandom_range(0, 99) < 85) ? st : 2'($urandom_range(0, 3));
            rdy = ($urandom_range(0, 1) != 0);
            tick(en, st, rdy);
            tests++;
            if ({e0_valid, e0_code, e0_ovf, c0_hit, c0_cnt} !==
                {m0.valid, m0.code, m0.ovf, m0.hit, m0.cnt[15:0]} ||
                (m0.valid && {e0_prev, e0_cur} !== {m0.prev, m0.cur})) begin
                fails++;
                $display("FAIL random_dut0 cycle %0d: got v=%b c=%0d p=%0d q=%0d o=%b h=%b n=%0d want v=%b c=%0d p=%0d q=%0d o=%b h=%b n=%0d",
                         i, e0_valid, e0_code, e0_prev, e0_cur, e0_ovf, c0_hit, c0_cnt,
                         m0.valid, m0.code, m0.prev, m0.cur, m0.ovf, m0.hit, m0.cnt);
            end
            tests++;
            if ({e1_valid, e1_code, e1_ovf, c1_hit, c1_cnt} !==
                {m1.valid, m1.code, m1.ovf, m1.hit, m1.cnt[3:0]} ||
                (m1.valid && {e1_prev, e1_cur} !== {m1.prev, m1.cur})) begin
                fails++;
                $display("FAIL random_dut1 cycle %0d: got v=%b c=%0d p=%0d q=%0d o=%b h=%b n=%0d want v=%b c=%0d p=%0d q=%0d o=%b h=%b n=%0d",
                         i, e1_valid, e1_code, e1_prev, e1_cur, e1_ovf, c1_hit, c1_cnt,
                         m1.valid, m1.code, m1.prev, m1.cur, m1.ovf, m1.hit, m1.cnt);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m0 = model_reset();
        m1 = model_reset();
        test_reset();
        test_legal_walk();
        test_rst_mismatch();
        test_illegal_overflow();
        test_back_to_back();
        test_stuck();
        test_cover_saturate();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
